i2s_tx: RTL and testbench

Audio output serializer at the back of the high-pass filter chain. It accepts one filtered k-bit sample per frame from the biquad stage (`audio_out` / `filter_done`) and transmits it as a standard Philips I2S stream, with the same sample in both left and right slots. It generates BCLK and LRCLK from the system clock. It also issues the per-frame `sample_trig` that paces the filter, closing the loop between the converter and the filter.

---
 rtl/i2s_tx_if.sv | 25 ++
 rtl/i2s_tx.sv | 107 ++++++++++
 tb/tb_i2s_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample-in / I2S-out bundle between the biquad filter, the serializer and the DAC pins.
// Master is the filter side (drives samples); slave is the serializer (drives the I2S lines and flags).
// No backpressure: audio_valid is a bare strobe and sample_trig paces the producer.
interface i2s_tx_if #(
    parameter int k = 24
);
    logic [k-1:0] audio_in;
    logic         audio_valid;
    logic         sample_trig;
    logic         bclk;
    logic         lrclk;
    logic         sdata;
    logic         overrun;
    logic         underrun;

    modport master (
        output audio_in, audio_valid,
        input  sample_trig, bclk, lrclk, sdata, overrun, underrun
    );

    modport slave (
        input  audio_in, audio_valid,
        output sample_trig, bclk, lrclk, sdata, overrun, underrun
    );
endinterface

// File: rtl/i2s_tx.sv
// Philips I2S serializer: one k-bit sample per frame, repeated in the left and right slots.
// Latency: a sample held before frame start N has its MSB on sdata one BCLK after that frame start.
// No backpressure: a second sample within a frame overwrites the hold (overrun); a missing one repeats (underrun).
module i2s_tx #(
    parameter int k    = 24,
    parameter int SLOT = 32,
    parameter int DIV  = 8
) (
    input  logic       clk,
    input  logic       reset,
    i2s_tx_if.slave    bus
);
    localparam int BW = $clog2(2 * SLOT);
    localparam int DW = $clog2(DIV);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);
    localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          bclk_r;
    logic [BW-1:0] bit_cnt;
    logic [k-1:0]  hold;
    logic          hold_valid;
    logic [k-1:0]  act;
    logic          lrclk_r;
    logic          sdata_r;
    logic          trig_r;
    logic          overrun_r;
    logic          underrun_r;

    logic          div_wrap;
    logic          fall;
    logic          frame_start;
    logic [BW-1:0] bit_nxt;
    logic [BW-1:0] slot_pos;
    logic          sd_nxt;

    always_comb begin
        div_wrap    = (div_cnt == LAST_DIV);
        fall        = div_wrap && bclk_r;
        bit_nxt     = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        frame_start = fall && (bit_nxt == '0);
        slot_pos    = (bit_nxt >= SLOT_B) ? bit_nxt - SLOT_B : bit_nxt;
        // Slot position p carries act[k-p]; p=0 is the one-BCLK I2S delay, p>k is padding.
        sd_nxt      = 1'b0;
        for (int i = 0; i < k; i++) begin
            if (slot_pos == BW'(k - i)) begin
                sd_nxt = act[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            bclk_r     <= 1'b0;
            bit_cnt    <= LAST_BIT;
            hold       <= '0;
            hold_valid <= 1'b0;
            act        <= '0;
            lrclk_r    <= 1'b0;
            sdata_r    <= 1'b0;
            trig_r     <= 1'b0;
            overrun_r  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            trig_r  <= 1'b0;
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bclk_r <= ~bclk_r;
            end

            if (fall) begin
                bit_cnt <= bit_nxt;
                lrclk_r <= (bit_nxt >= SLOT_B);
                sdata_r <= sd_nxt;
                trig_r  <= frame_start;
            end

            if (frame_start) begin
                if (hold_valid) begin
                    act <= hold;
                end else begin
                    underrun_r <= 1'b1;
                end
            end

            // A strobe coinciding with frame start refills the hold the transfer just emptied.
            if (bus.audio_valid) begin
                hold       <= bus.audio_in;
                hold_valid <= 1'b1;
                if (hold_valid && !frame_start) begin
                    overrun_r <= 1'b1;
                end
            end else if (frame_start) begin
                hold_valid <= 1'b0;
            end
        end
    end

    assign bus.bclk        = bclk_r;
    assign bus.lrclk       = lrclk_r;
    assign bus.sdata       = sdata_r;
    assign bus.sample_trig = trig_r;
    assign bus.overrun     = overrun_r;
    assign bus.underrun    = underrun_r;
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx (k=24, SLOT=32, DIV=2): startup timing, frame contents, stream pacing,
// underrun/overrun flags, valid coinciding with frame start, and mid-frame reset.
module tb_i2s_tx;
    localparam int K    = 24;
    localparam int SLOT = 32;
    localparam int DIV  = 2;
    localparam logic [63:0] LR_EXP = {32'h0000_0000, 32'hFFFF_FFFF};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    i2s_tx_if #(.k(K)) bus ();

    i2s_tx #(.k(K), .SLOT(SLOT), .DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame_of(input logic [23:0] s);
        return {1'b0, s, 7'b0, 1'b0, s, 7'b0};
    endfunction

    function automatic logic [63:0] outs();
        return {58'd0, bus.bclk, bus.lrclk, bus.sdata, bus.sample_trig, bus.overrun, bus.underrun};
    endfunction

    task automatic wait_trig(output int tc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sample_trig !== 1'b1 && n < 600);
        chk("trig_seen", 64'(bus.sample_trig), 64'd1);
        tc = cyc;
    endtask

    // Records the 64 bits of one frame (sampled in each BCLK high phase); optionally strobes
    // up to two samples kk cycles after the frame's sample_trig.
    task automatic capture(input bit skip_wait,
                           input logic [23:0] v1, input int at1,
                           input logic [23:0] v2, input int at2,
                           output logic [63:0] sd, output logic [63:0] lr, output int tc);
        int   kk = 0;
        int   n = 0;
        logic prev = 1'b0;
        if (skip_wait) tc = cyc;
        else wait_trig(tc);
        sd = '0;
        lr = '0;
        while (n < 64 && kk < 400) begin
            @(negedge clk);
            kk++;
            bus.audio_valid = 1'b0;
            if (kk == at1) begin bus.audio_in = v1; bus.audio_valid = 1'b1; end
            if (kk == at2) begin bus.audio_in = v2; bus.audio_valid = 1'b1; end
            if (bus.bclk && !prev) begin
                sd = {sd[62:0], bus.sdata};
                lr = {lr[62:0], bus.lrclk};
                n++;
            end
            prev = bus.bclk;
        end
        chk("bits_seen", 64'(n), 64'd64);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.audio_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 64'd0);
        reset = 1'b0;
    endtask

    // Called at the negedge where reset was released; returns at the first sample_trig.
    task automatic check_startup();
        @(negedge clk);
        bus.audio_valid = 1'b0;
        chk("bclk_c1", 64'(bus.bclk), 64'd0);
        @(negedge clk);
        chk("bclk_rise_c2", 64'(bus.bclk), 64'd1);
        @(negedge clk);
        chk("trig_c3", 64'({bus.sample_trig, bus.bclk}), 64'b01);
        @(negedge clk);
        chk("trig_c4", 64'({bus.sample_trig, bus.bclk, bus.lrclk, bus.sdata}), 64'b1000);
    endtask

    logic [23:0] s [0:8];
    logic [63:0] sd, lr;
    int tc, prev_tc;

    initial begin
        s[0] = 24'h800000; s[1] = 24'h7FFFFF; s[2] = 24'h000001;
        s[3] = 24'hFFFFFF; s[4] = 24'h123ABC; s[5] = 24'h555555;
        s[6] = 24'hAAAAAA; s[7] = 24'h0F0F0F; s[8] = 24'hC3C3C3;
        bus.audio_in    = '0;
        bus.audio_valid = 1'b0;

        // Reset and first frame
        do_reset();
        check_startup();

        // Single sample strobed at cycle 10, transmitted in frame 2
        repeat (6) @(negedge clk);
        bus.audio_in = 24'hA53C0F;
        bus.audio_valid = 1'b1;
        @(negedge clk);
        bus.audio_valid = 1'b0;
        capture(1'b0, '0, -1, '0, -1, sd, lr, tc);
        chk("single_data", sd, frame_of(24'hA53C0F));
        chk("single_lr", lr, LR_EXP);
        chk("first_frame_underrun", 64'(bus.underrun), 64'd1);

        // Continuous stream, first sample preloaded before the first frame start
        do_reset();
        bus.audio_in = s[0];
        bus.audio_valid = 1'b1;
        check_startup();
        prev_tc = 0;
        for (int f = 1; f <= 8; f++) begin
            capture(f == 1, s[f], 20, '0, -1, sd, lr, tc);
            chk($sformatf("stream_data_f%0d", f), sd, frame_of(s[f-1]));
            chk($sformatf("stream_lr_f%0d", f), lr, LR_EXP);
            if (f > 1) chk($sformatf("trig_period_f%0d", f), 64'(tc - prev_tc), 64'd256);
            prev_tc = tc;
        end
        chk("stream_flags", 64'({bus.overrun, bus.underrun}), 64'd0);

        // Frame 9 loads 123456; 654321 arrives exactly on frame 10's start
        capture(1'b0, 24'h123456, 20, '0, -1, sd, lr, tc);
        chk("f9_data", sd, frame_of(s[8]));
        @(negedge clk);
        bus.audio_in = 24'h654321;
        bus.audio_valid = 1'b1;
        @(negedge clk);
        bus.audio_valid = 1'b0;
        chk("coincide_trig", 64'(bus.sample_trig), 64'd1);
        capture(1'b1, '0, -1, '0, -1, sd, lr, tc);
        chk("coincide_old", sd, frame_of(24'h123456));
        chk("coincide_no_overrun", 64'(bus.overrun), 64'd0);
        capture(1'b0, '0, -1, '0, -1, sd, lr, tc);
        chk("coincide_new", sd, frame_of(24'h654321));
        chk("no_underrun_yet", 64'(bus.underrun), 64'd0);

        // Underrun: nothing sent during frame 11, frame 12 repeats
        capture(1'b0, '0, -1, '0, -1, sd, lr, tc);
        chk("underrun_repeat", sd, frame_of(24'h654321));
        chk("underrun_flag", 64'(bus.underrun), 64'd1);

        // Overrun: two strobes in frame 13, newest goes out in frame 14
        capture(1'b0, 24'h000001, 20, 24'h7FFFFF, 60, sd, lr, tc);
        chk("overrun_flag", 64'(bus.overrun), 64'd1);
        capture(1'b0, '0, -1, '0, -1, sd, lr, tc);
        chk("overrun_newest", sd, frame_of(24'h7FFFFF));
        chk("underrun_sticky", 64'(bus.underrun), 64'd1);

        // Mid-frame reset at bit_cnt=40
        wait_trig(tc);
        repeat (160) @(negedge clk);
        chk("mid_bit40", 64'({bus.lrclk, bus.bclk}), 64'b10);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outs", outs(), 64'd0);
        do_reset();
        check_startup();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
